// File: rtl/fp_add_arbiter_pkg.sv
// fp_add_arbiter_pkg
// Purpose: shared widths, default adder latency, fp16 constants and the
//          tag type carried alongside the adder pipeline.
// Ports:   none (package).
package fp_add_arbiter_pkg;

   localparam int FP16_W            = 16;
   localparam int ADDER_LAT_DEFAULT = 4;

   // Tag id is sized for the largest supported requester count (8), so the
   // type can live in a package without depending on the NREQ parameter.
   localparam int MAX_ID_W = 3;

   localparam logic [FP16_W-1:0] FP16_ONE   = 16'h3C00;
   localparam logic [FP16_W-1:0] FP16_TWO   = 16'h4000;
   localparam logic [FP16_W-1:0] FP16_THREE = 16'h4200;
   localparam logic [FP16_W-1:0] FP16_FOUR  = 16'h4400;

   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/fp_add_arbiter_rsp_fifo.sv
// fp_add_arbiter_rsp_fifo
// Purpose: single-requester first-word fall-through response FIFO.
// Ports:
//   clk73, rst_n73  clock (rising edge), asynchronous active-low reset
//   wr_en_i         write wr_data_i at the end of this cycle
//   wr_data_i       sum coming off the adder
//   pop_i           consume the head entry (ignored when empty)
//   valid_o         FIFO holds at least one entry
//   head_o          head entry, or 0 when empty
module fp_add_arbiter_rsp_fifo
   import fp_add_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk73,
   input  logic              rst_n73,
   input  logic              wr_en_i,
   input  logic [FP16_W-1:0] wr_data_i,
   input  logic              pop_i,
   output logic              valid_o,
   output logic [FP16_W-1:0] head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [FP16_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign valid_o = (count_q != '0);
   assign do_pop  = pop_i & valid_o;
   assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = wr_en_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(wr_en_i) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk73 or negedge rst_n73) begin
      if (!rst_n73) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; count_q alone decides what is visible.
   // On a full FIFO with a same-cycle pop the write lands in the slot that
   // the pop is vacating, which is safe because the head is read combinationally.
   always_ff @(posedge clk73) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Credits make this unreachable; firing means the credit accounting broke.
   a_no_overflow: assert property (@(posedge clk73) disable iff (!rst_n73)
      !(wr_en_i && (count_q == CNT_W'(DEPTH)) && !pop_i));

endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
// Purpose: shares one fixed-latency fp16 adder (no valid/stall) among NREQ
//          requesters with round-robin grant, credit-based flow control and
//          a per-requester response FIFO.
// Ports:
//   clk73, rst_n73            clock (rising edge), asynchronous active-low reset
//   req_valid73/req_ready73   per-requester request handshake (ready one-hot/zero)
//   req_a73/req_b73           fp16 operands, 16-bit slice per requester
//   rsp_valid73/rsp_ready73   per-requester response handshake
//   rsp_sum73                 FIFO head sum per requester (0 when empty)
//   adder_a73/adder_b73       operands to the external adder (0 when idle)
//   adder_sum73               sum from the adder, ADDER_LAT cycles later
//   busy73                    any op in flight or any response stored
module fp_add_arbiter
   import fp_add_arbiter_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int ADDER_LAT = ADDER_LAT_DEFAULT,
   parameter int RSP_DEPTH = 2
) (
   input  logic                   clk73,
   input  logic                   rst_n73,
   input  logic [NREQ-1:0]        req_valid73,
   output logic [NREQ-1:0]        req_ready73,
   input  logic [FP16_W*NREQ-1:0] req_a73,
   input  logic [FP16_W*NREQ-1:0] req_b73,
   output logic [NREQ-1:0]        rsp_valid73,
   input  logic [NREQ-1:0]        rsp_ready73,
   output logic [FP16_W*NREQ-1:0] rsp_sum73,
   output logic [FP16_W-1:0]      adder_a73,
   output logic [FP16_W-1:0]      adder_b73,
   input  logic [FP16_W-1:0]      adder_sum73,
   output logic                   busy73
);

   localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);

   logic [ID_W-1:0] ptr_q, ptr_d;
   tag_t            tag_q [ADDER_LAT];
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] wr_en;
   logic            gnt_any;
   logic [ID_W-1:0] gnt_id;

   // Per-requester credit counter and response FIFO.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             pop;

      assign pop          = rsp_valid73[gi] & rsp_ready73[gi];
      assign wr_en[gi]    = tag_q[ADDER_LAT-1].valid &&
                            (tag_q[ADDER_LAT-1].id == MAX_ID_W'(gi));
      // Gating with rst_n73 keeps ready low while reset is held.
      assign eligible[gi] = rst_n73 & req_valid73[gi] & (cnt_q < CNT_W'(RSP_DEPTH));
      // The retire write does not touch the credit; only issue and pop do.
      assign cnt_d        = cnt_q + CNT_W'(req_ready73[gi]) - CNT_W'(pop);

      always_ff @(posedge clk73 or negedge rst_n73) begin
         if (!rst_n73) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      fp_add_arbiter_rsp_fifo #(
         .DEPTH(RSP_DEPTH)
      ) u_rsp_fifo (
         .clk73    (clk73),
         .rst_n73  (rst_n73),
         .wr_en_i  (wr_en[gi]),
         .wr_data_i(adder_sum73),
         .pop_i    (pop),
         .valid_o  (rsp_valid73[gi]),
         .head_o   (rsp_sum73[gi*FP16_W +: FP16_W])
      );
   end

   // Round-robin search from ptr_q upward with wrap. Scanning from the far
   // end and overwriting leaves the nearest eligible requester as winner.
   always_comb begin
      int idx;
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (eligible[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready73 = '0;
      adder_a73   = '0;
      adder_b73   = '0;
      ptr_d       = ptr_q;
      if (gnt_any) begin
         req_ready73[gnt_id] = 1'b1;
         adder_a73           = req_a73[gnt_id*FP16_W +: FP16_W];
         adder_b73           = req_b73[gnt_id*FP16_W +: FP16_W];
         ptr_d               = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end
   end

   // Tag pipe mirrors the adder latency; it shifts every cycle because the
   // adder itself never stalls.
   always_ff @(posedge clk73 or negedge rst_n73) begin
      if (!rst_n73) begin
         ptr_q <= '0;
         for (int k = 0; k < ADDER_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         ptr_q    <= ptr_d;
         tag_q[0] <= '{valid: gnt_any, id: MAX_ID_W'(gnt_id)};
         for (int k = 1; k < ADDER_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   always_comb begin
      busy73 = |rsp_valid73;
      for (int k = 0; k < ADDER_LAT; k++) begin
         busy73 = busy73 | tag_q[k].valid;
      end
   end

endmodule
